// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file types and defaults
package rv_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [$clog2(NREGS_DEF)-1:0] regaddr_t;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with set/clear/flush priority
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              sb_set_en,
    input  logic [AW-1:0]     sb_set_addr,
    input  logic              sb_flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Flush and writeback clear first; a same-cycle issue marks the younger producer.
    always_comb begin
        busy_d = busy_q;
        if (active) begin
            if (sb_flush) begin
                busy_d = '0;
            end
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k]) begin
                    busy_d[wr_addr[k*AW +: AW]] = 1'b0;
                end
            end
            if (sb_set_en) begin
                busy_d[sb_set_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          hit;
            a   = rd_addr[i*AW +: AW];
            hit = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) begin
                    hit = 1'b1;
                end
            end
            rd_busy[i] = active && busy_q[a] && !((BYPASS != 0) && hit);
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with clear sequencer and scoreboard
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    input  logic                sb_flush
);
    rf_state_e       state_q;
    rf_state_e       state_d;
    logic [AW-1:0]   cnt_q;
    logic [XLEN-1:0] regs [NREGS];
    logic            ready;

    assign ready     = (state_q == RF_READY);
    assign init_done = rst_n && ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RF_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == RF_INIT) && (cnt_q == AW'(NREGS - 1))) begin
            state_d = RF_READY;
        end
    end

    // Storage has no reset of its own; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == RF_INIT) begin
                regs[cnt_q] <= '0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) begin
                        regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] v;
            a = rd_addr[i*AW +: AW];
            v = '0;
            if (ready && (a != '0)) begin
                v = regs[a];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) begin
                            v = wr_data[k*XLEN +: XLEN];
                        end
                    end
                end
            end
            rd_data[i*XLEN +: XLEN] = v;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy)
    );
endmodule
